// File: rtl/modmul_issue_pkg.sv
// Shared widths, latencies, FSM encoding and config payload for the modmul issue stage.
package modmul_issue_pkg;

    localparam int unsigned OP_W   = 30;
    localparam int unsigned PROD_W = 60;
    localparam int unsigned BAR_W  = 31;
    localparam int unsigned TAG_W  = 4;

    localparam int unsigned DEF_RED_LAT  = 11;
    localparam int unsigned DEF_MUL_LAT  = 2;
    localparam int unsigned DEF_CRED_MAX = 16;

    typedef enum logic [1:0] {
        ST_UNCFG = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic [OP_W-1:0]  prime;
        logic [BAR_W-1:0] barrett;
    } cfg_t;

endpackage

// File: rtl/modmul_issue_if.sv
// Config, operand, reduction-core and result signals of the modmul issue stage.
interface modmul_issue_if;
    import modmul_issue_pkg::*;

    logic               cfg_load;
    logic [OP_W-1:0]    cfg_prime;
    logic [BAR_W-1:0]   cfg_barrett;
    logic               op_valid;
    logic               op_ready;
    logic [OP_W-1:0]    op_a;
    logic [OP_W-1:0]    op_b;
    logic [TAG_W-1:0]   op_tag;
    logic [PROD_W-1:0]  red_a;
    logic [OP_W-1:0]    red_prime;
    logic [BAR_W-1:0]   red_barrett;
    logic               res_valid;
    logic [TAG_W-1:0]   res_tag;
    logic               cred_ret;
    logic               busy;

    modport master (
        output cfg_load, cfg_prime, cfg_barrett, op_valid, op_a, op_b, op_tag, cred_ret,
        input  op_ready, red_a, red_prime, red_barrett, res_valid, res_tag, busy
    );

    modport slave (
        input  cfg_load, cfg_prime, cfg_barrett, op_valid, op_a, op_b, op_tag, cred_ret,
        output op_ready, red_a, red_prime, red_barrett, res_valid, res_tag, busy
    );

endinterface

// File: rtl/issue_mul30.sv
// Pipelined 30x30 unsigned multiplier: operand register then LAT-1 product registers.
// Every stage only loads when its upstream stage holds a valid entry, so the output holds otherwise.
module issue_mul30
    import modmul_issue_pkg::*;
#(
    parameter int unsigned LAT = DEF_MUL_LAT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_valid,
    input  logic [OP_W-1:0]   i_a,
    input  logic [OP_W-1:0]   i_b,
    output logic [PROD_W-1:0] o_prod
);

    localparam int unsigned NP = LAT - 1;

    logic [OP_W-1:0]   r_a;
    logic [OP_W-1:0]   r_b;
    // r_v[0]: operand stage valid; r_v[j]: product stage j-1 valid
    logic [NP-1:0]     r_v;
    logic [PROD_W-1:0] r_prod [NP];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a <= '0;
            r_b <= '0;
            r_v <= '0;
            for (int j = 0; j < NP; j++) r_prod[j] <= '0;
        end else begin
            r_v[0] <= i_valid;
            for (int j = 1; j < NP; j++) r_v[j] <= r_v[j-1];
            if (i_valid) begin
                r_a <= i_a;
                r_b <= i_b;
            end
            if (r_v[0]) r_prod[0] <= PROD_W'(r_a) * PROD_W'(r_b);
            for (int j = 1; j < NP; j++) begin
                if (r_v[j]) r_prod[j] <= r_prod[j-1];
            end
        end
    end

    assign o_prod = r_prod[NP-1];

endmodule

// File: rtl/modmul_issue.sv
// Issue stage in front of a Barrett reduction core: credit-gated operand accept, multiply,
// result valid/tag delay line, and modulus updates deferred until the pipeline is empty.
module modmul_issue #(
    parameter int unsigned RED_LAT  = modmul_issue_pkg::DEF_RED_LAT,
    parameter int unsigned MUL_LAT  = modmul_issue_pkg::DEF_MUL_LAT,
    parameter int unsigned CRED_MAX = modmul_issue_pkg::DEF_CRED_MAX
) (
    input  logic          clk,
    input  logic          rst_n,
    modmul_issue_if.slave bus
);
    import modmul_issue_pkg::*;

    localparam int unsigned DL_N   = MUL_LAT + RED_LAT;
    localparam int unsigned CRED_W = $clog2(CRED_MAX + 1);
    localparam int unsigned INFL_W = $clog2(DL_N + 1);

    state_t                        r_state;
    state_t                        w_state_nxt;
    logic [CRED_W-1:0]             r_credits;
    logic [CRED_W-1:0]             w_credits_nxt;
    logic [INFL_W-1:0]             r_inflight;
    logic [INFL_W-1:0]             w_inflight_nxt;
    logic                          r_op_ready;
    logic                          w_op_ready_nxt;
    logic                          r_busy;
    cfg_t                          r_cfg_act;
    cfg_t                          r_cfg_pend;
    cfg_t                          w_cfg_in;
    cfg_t                          w_cfg_apply_val;
    logic                          w_cfg_apply;
    logic                          w_pend_load;
    logic                          w_fire;
    logic                          w_res;
    logic [DL_N-1:0]               r_dl_v;
    logic [DL_N-1:0][TAG_W-1:0]    r_dl_tag;
    logic [PROD_W-1:0]             w_prod;

    assign w_fire   = bus.op_valid & r_op_ready;
    assign w_res    = r_dl_v[DL_N-1];
    assign w_cfg_in = '{prime: bus.cfg_prime, barrett: bus.cfg_barrett};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_UNCFG;
        else        r_state <= w_state_nxt;
    end

    // Next state, config routing, counters and registered-output next values
    always_comb begin
        w_state_nxt     = r_state;
        w_cfg_apply     = 1'b0;
        w_pend_load     = 1'b0;
        w_cfg_apply_val = w_cfg_in;
        w_credits_nxt   = r_credits;
        w_inflight_nxt  = r_inflight;

        case (r_state)
            ST_UNCFG: begin
                if (bus.cfg_load) begin
                    w_cfg_apply = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.cfg_load) begin
                    if (r_inflight == INFL_W'(0)) begin
                        w_cfg_apply = 1'b1;
                    end else begin
                        w_pend_load = 1'b1;
                        w_state_nxt = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (bus.cfg_load) w_pend_load = 1'b1;
                if (r_inflight == INFL_W'(0)) begin
                    w_cfg_apply = 1'b1;
                    w_state_nxt = ST_RUN;
                    if (!bus.cfg_load) w_cfg_apply_val = r_cfg_pend;
                end
            end
            default: w_state_nxt = ST_UNCFG;
        endcase

        if (w_fire && !bus.cred_ret) begin
            w_credits_nxt = r_credits - CRED_W'(1);
        end else if (!w_fire && bus.cred_ret && (r_credits < CRED_W'(CRED_MAX))) begin
            w_credits_nxt = r_credits + CRED_W'(1);
        end

        if (w_fire && !w_res)      w_inflight_nxt = r_inflight + INFL_W'(1);
        else if (!w_fire && w_res) w_inflight_nxt = r_inflight - INFL_W'(1);

        w_op_ready_nxt = (w_state_nxt == ST_RUN) && (w_credits_nxt != CRED_W'(0));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_credits  <= CRED_W'(CRED_MAX);
            r_inflight <= '0;
            r_op_ready <= 1'b0;
            r_busy     <= 1'b0;
            r_cfg_act  <= '0;
            r_cfg_pend <= '0;
        end else begin
            r_credits  <= w_credits_nxt;
            r_inflight <= w_inflight_nxt;
            r_op_ready <= w_op_ready_nxt;
            r_busy     <= (w_inflight_nxt != INFL_W'(0));
            if (w_cfg_apply) r_cfg_act  <= w_cfg_apply_val;
            if (w_pend_load) r_cfg_pend <= w_cfg_in;
        end
    end

    // Valid/tag delay line spanning multiply plus reduction latency; idle slots carry tag 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dl_v   <= '0;
            r_dl_tag <= '0;
        end else begin
            r_dl_v   <= {r_dl_v[DL_N-2:0], w_fire};
            r_dl_tag <= {r_dl_tag[DL_N-2:0], (w_fire ? bus.op_tag : TAG_W'(0))};
        end
    end

    issue_mul30 #(
        .LAT (MUL_LAT)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (w_fire),
        .i_a     (bus.op_a),
        .i_b     (bus.op_b),
        .o_prod  (w_prod)
    );

    assign bus.op_ready    = r_op_ready;
    assign bus.busy        = r_busy;
    assign bus.red_a       = w_prod;
    assign bus.red_prime   = r_cfg_act.prime;
    assign bus.red_barrett = r_cfg_act.barrett;
    assign bus.res_valid   = r_dl_v[DL_N-1];
    assign bus.res_tag     = r_dl_tag[DL_N-1];

endmodule

// File: tb/tb_modmul_issue.sv
// Directed bench for modmul_issue with a cycle-stamped scoreboard for products and result tags.
module tb_modmul_issue;
    import modmul_issue_pkg::*;

    localparam int unsigned LAT = DEF_MUL_LAT + DEF_RED_LAT;
    localparam logic [29:0] P1  = 30'h3FFC0001;    // 1073479681
    localparam logic [29:0] P2  = 30'd1073741789;
    localparam logic [29:0] P3  = 30'h3FFFFFF1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    modmul_issue_if bus();

    modmul_issue u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int          due;
        logic [63:0] val;
    } exp_t;

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          last_res_cyc = 0;
    logic [59:0] drv_exp = '0;
    exp_t        q_mul[$];
    exp_t        q_res[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [30:0] barrett_of(input logic [29:0] p);
        logic [63:0] t;
        t = (64'h1 << 60) / 64'(p);
        return t[30:0];
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: product due 2 cycles after fire, result tag due LAT cycles after fire
    always @(negedge clk) begin
        if (!rst_n) begin
            q_mul.delete();
            q_res.delete();
        end else begin
            if (bus.op_valid && bus.op_ready) begin
                q_mul.push_back('{cyc + DEF_MUL_LAT, 64'(drv_exp)});
                q_res.push_back('{cyc + LAT, 64'(bus.op_tag)});
            end
            if (q_mul.size() > 0 && q_mul[0].due == cyc) begin
                exp_t e;
                e = q_mul.pop_front();
                check("red_a", 64'(bus.red_a), e.val);
            end
            if (q_res.size() > 0 && q_res[0].due == cyc) begin
                exp_t e;
                e = q_res.pop_front();
                check("res_valid", 64'(bus.res_valid), 64'd1);
                check("res_tag", 64'(bus.res_tag), e.val);
                last_res_cyc = cyc;
            end else if (bus.res_valid) begin
                check("res_spurious", 64'(bus.res_valid), 64'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic set_payload(input int idx);
        bus.op_a   = 30'(idx * 7919 + 13);
        bus.op_b   = 30'(idx * 104729 + 1);
        bus.op_tag = 4'(idx);
        drv_exp    = 60'(64'(bus.op_a) * 64'(bus.op_b));
    endtask

    task automatic fire_one(input logic [29:0] a, input logic [29:0] b,
                            input logic [3:0] tag, input logic [59:0] exp);
        bus.op_a     = a;
        bus.op_b     = b;
        bus.op_tag   = tag;
        drv_exp      = exp;
        bus.op_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (bus.op_ready) break;
            tick();
        end
        check("fire_ready", 64'(bus.op_ready), 64'd1);
        tick();
        bus.op_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx = 0;
        int acc;
        int n_lo;
        int n_rv;
        logic early;

        bus.cfg_load    = 1'b0;
        bus.cfg_prime   = '0;
        bus.cfg_barrett = '0;
        bus.op_valid    = 1'b0;
        bus.op_a        = '0;
        bus.op_b        = '0;
        bus.op_tag      = '0;
        bus.cred_ret    = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_op_ready", 64'(bus.op_ready), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_red_a", 64'(bus.red_a), 64'd0);
        check("rst_red_prime", 64'(bus.red_prime), 64'd0);
        check("rst_red_barrett", 64'(bus.red_barrett), 64'd0);
        check("rst_res_valid", 64'(bus.res_valid), 64'd0);
        check("rst_res_tag", 64'(bus.res_tag), 64'd0);
        rst_n = 1'b1;
        idle(2);
        check("uncfg_ready", 64'(bus.op_ready), 64'd0);

        // Configure from UNCFG
        bus.cfg_load    = 1'b1;
        bus.cfg_prime   = P1;
        bus.cfg_barrett = barrett_of(P1);
        tick();
        bus.cfg_load = 1'b0;
        check("cfg_prime", 64'(bus.red_prime), 64'(P1));
        check("cfg_barrett", 64'(bus.red_barrett), 64'(31'd1074004031));
        check("cfg_ready", 64'(bus.op_ready), 64'd1);

        // Single operations with hand-computed products
        fire_one(P1 - 30'd1, P1 - 30'd1, 4'd5, 60'hFFE001000000000);
        check("busy_after_fire", 64'(bus.busy), 64'd1);
        fire_one(30'd3, 30'd5, 4'd1, 60'd15);
        fire_one(30'h3FFFFFFF, 30'h3FFFFFFF, 4'd2, 60'hFFFFFFF80000001);
        idle(LAT + 2);
        check("idle_busy", 64'(bus.busy), 64'd0);

        // Return the 3 used credits plus one excess that must be ignored
        bus.cred_ret = 1'b1;
        idle(4);
        bus.cred_ret = 1'b0;

        // Back-to-back until credits run out, then 4 single returns
        acc = 0;
        bus.op_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            set_payload(idx);
            if (bus.op_ready) begin acc++; idx++; end
            tick();
        end
        check("b2b_accepted", 64'(acc), 64'd16);
        check("b2b_ready_low", 64'(bus.op_ready), 64'd0);
        acc = 0;
        for (int k = 0; k < 16; k++) begin
            set_payload(idx);
            bus.cred_ret = ((k % 3) == 0) && (k < 12);
            if (bus.op_ready) begin acc++; idx++; end
            tick();
        end
        bus.cred_ret = 1'b0;
        bus.op_valid = 1'b0;
        check("cred_ret_accepted", 64'(acc), 64'd4);
        idle(LAT + 4);

        // Credits 3, then fire and cred_ret together: 3 more accepted afterwards
        bus.cred_ret = 1'b1;
        idle(3);
        bus.cred_ret = 1'b0;
        set_payload(idx);
        bus.op_valid = 1'b1;
        bus.cred_ret = 1'b1;
        check("both_ready", 64'(bus.op_ready), 64'd1);
        tick();
        idx++;
        bus.cred_ret = 1'b0;
        acc = 0;
        for (int k = 0; k < 6; k++) begin
            set_payload(idx);
            if (bus.op_ready) begin acc++; idx++; end
            tick();
        end
        bus.op_valid = 1'b0;
        check("cred3_accepted", 64'(acc), 64'd3);
        idle(LAT + 2);

        // Refill, 5 in flight, reconfigure through DRAIN (second load wins)
        bus.cred_ret = 1'b1;
        idle(16);
        bus.cred_ret = 1'b0;
        bus.op_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            set_payload(idx);
            idx++;
            tick();
        end
        bus.op_valid    = 1'b0;
        bus.cfg_load    = 1'b1;
        bus.cfg_prime   = P3;
        bus.cfg_barrett = barrett_of(P3);
        check("cfg_busy", 64'(bus.busy), 64'd1);
        tick();
        bus.cfg_prime   = P2;
        bus.cfg_barrett = barrett_of(P2);
        check("drain_entry_ready", 64'(bus.op_ready), 64'd0);
        tick();
        bus.cfg_load = 1'b0;
        n_lo  = 0;
        early = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (bus.op_ready) break;
            n_lo++;
            if (bus.red_prime != P1) early = 1'b1;
            tick();
        end
        check("drain_len_ge5", 64'(n_lo >= 5), 64'd1);
        check("drain_prime_held", 64'(early), 64'd0);
        check("new_prime", 64'(bus.red_prime), 64'(P2));
        check("new_barrett", 64'(bus.red_barrett), 64'(barrett_of(P2)));
        check("prime_after_last_res", 64'(cyc > last_res_cyc), 64'd1);
        fire_one(P2 - 30'd1, P2 - 30'd1, 4'd9, 60'(64'(P2 - 30'd1) * 64'(P2 - 30'd1)));
        fire_one(30'd2, 30'd3, 4'd10, 60'd6);
        idle(LAT + 2);

        // Idle reconfigure takes effect immediately and stays in RUN
        bus.cfg_load    = 1'b1;
        bus.cfg_prime   = P1;
        bus.cfg_barrett = barrett_of(P1);
        tick();
        bus.cfg_load = 1'b0;
        check("idle_cfg_prime", 64'(bus.red_prime), 64'(P1));
        check("idle_cfg_ready", 64'(bus.op_ready), 64'd1);

        // Reset with 8 operations in flight
        bus.op_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            set_payload(idx);
            idx++;
            tick();
        end
        bus.op_valid = 1'b0;
        check("pre_rst_busy", 64'(bus.busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_op_ready", 64'(bus.op_ready), 64'd0);
        check("mid_rst_busy", 64'(bus.busy), 64'd0);
        check("mid_rst_red_a", 64'(bus.red_a), 64'd0);
        check("mid_rst_red_prime", 64'(bus.red_prime), 64'd0);
        check("mid_rst_red_barrett", 64'(bus.red_barrett), 64'd0);
        check("mid_rst_res_valid", 64'(bus.res_valid), 64'd0);
        check("mid_rst_res_tag", 64'(bus.res_tag), 64'd0);
        tick();
        rst_n = 1'b1;
        n_rv = 0;
        for (int k = 0; k < 20; k++) begin
            if (bus.res_valid) n_rv++;
            tick();
        end
        check("post_rst_no_res", 64'(n_rv), 64'd0);
        check("post_rst_uncfg_ready", 64'(bus.op_ready), 64'd0);
        check("post_rst_busy", 64'(bus.busy), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
